// File: rtl/arm_motion_seq.sv
// Move-command sequencer for the arm angle/PWM stage: ramps two joint angles
// toward clamped targets at one degree per step, then applies the gripper and
// holds for a settle time before reporting completion.
//
// state  | meaning
// S_IDLE | ready for a command, angles held
// S_MOVE | stepping xita1/xita2 toward the latched targets
// S_GRIP | gripper applied, waiting out the settle time if it changed
// S_DONE | one-cycle completion pulse
module arm_motion_seq #(
   parameter int unsigned STEP_DIV  = 500_000,
   parameter int unsigned GRIP_WAIT = 25_000_000,
   parameter int unsigned ANGLE_MAX = 180,
   parameter int unsigned HOME1     = 90,
   parameter int unsigned HOME2     = 90
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [31:0] cmd_xita1,
   input  logic [31:0] cmd_xita2,
   input  logic        cmd_catch,
   output logic [31:0] xita1,
   output logic [31:0] xita2,
   output logic        catch,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {S_IDLE, S_MOVE, S_GRIP, S_DONE} state_t;

   localparam logic [31:0] MAX_A     = 32'(ANGLE_MAX);
   localparam logic [31:0] HOME1_A   = 32'(HOME1);
   localparam logic [31:0] HOME2_A   = 32'(HOME2);
   localparam logic [31:0] STEP_LAST = 32'(STEP_DIV - 1);
   localparam logic [31:0] WAIT_LAST = 32'(GRIP_WAIT - 1);
   // The accept cycle is the first tick of the first step period, so the
   // timer enters MOVE already at 1 and each step lands STEP_DIV cycles apart.
   localparam logic [31:0] STEP_FIRST = (STEP_DIV > 1) ? 32'd1 : 32'd0;

   state_t      state_q, state_d;
   logic [31:0] xita1_q, xita1_d, xita2_q, xita2_d;
   logic [31:0] tgt1_q, tgt1_d, tgt2_q, tgt2_d;
   logic [31:0] timer_q, timer_d;
   logic [31:0] grip_cnt_q, grip_cnt_d;
   logic        tgt_catch_q, tgt_catch_d;
   logic        catch_q, catch_d;
   logic        grip_chg_q, grip_chg_d;
   logic        grip_load_q, grip_load_d;
   logic        ready_q, ready_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;

   // Next-state and datapath decisions for the sequencer.
   always_comb begin
      state_d     = state_q;
      xita1_d     = xita1_q;
      xita2_d     = xita2_q;
      tgt1_d      = tgt1_q;
      tgt2_d      = tgt2_q;
      tgt_catch_d = tgt_catch_q;
      timer_d     = timer_q;
      grip_cnt_d  = grip_cnt_q;
      catch_d     = catch_q;
      grip_chg_d  = grip_chg_q;
      grip_load_d = grip_load_q;
      case (state_q)
         S_IDLE: begin
            if (cmd_valid && ready_q) begin
               tgt1_d      = (cmd_xita1 > MAX_A) ? MAX_A : cmd_xita1;
               tgt2_d      = (cmd_xita2 > MAX_A) ? MAX_A : cmd_xita2;
               tgt_catch_d = cmd_catch;
               timer_d     = STEP_FIRST;
               state_d     = S_MOVE;
            end
         end
         S_MOVE: begin
            if ((xita1_q == tgt1_q) && (xita2_q == tgt2_q)) begin
               // Gripper output switches on the same edge that enters GRIP;
               // the settle count is loaded during that first GRIP cycle.
               catch_d     = tgt_catch_q;
               grip_chg_d  = (tgt_catch_q != catch_q);
               grip_load_d = 1'b1;
               timer_d     = 32'd0;
               state_d     = S_GRIP;
            end else if (timer_q == STEP_LAST) begin
               timer_d = 32'd0;
               if (xita1_q < tgt1_q) begin
                  xita1_d = xita1_q + 32'd1;
               end else if (xita1_q > tgt1_q) begin
                  xita1_d = xita1_q - 32'd1;
               end
               if (xita2_q < tgt2_q) begin
                  xita2_d = xita2_q + 32'd1;
               end else if (xita2_q > tgt2_q) begin
                  xita2_d = xita2_q - 32'd1;
               end
            end else begin
               timer_d = timer_q + 32'd1;
            end
         end
         S_GRIP: begin
            if (!grip_chg_q) begin
               state_d = S_DONE;
            end else if (grip_load_q) begin
               grip_cnt_d  = WAIT_LAST;
               grip_load_d = 1'b0;
            end else if (grip_cnt_q == 32'd0) begin
               state_d = S_DONE;
            end else begin
               grip_cnt_d = grip_cnt_q - 32'd1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      ready_d = (state_d == S_IDLE);
      busy_d  = (state_d != S_IDLE);
      done_d  = (state_d == S_DONE);
   end

   // State, datapath and registered outputs, with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         xita1_q     <= HOME1_A;
         xita2_q     <= HOME2_A;
         tgt1_q      <= HOME1_A;
         tgt2_q      <= HOME2_A;
         tgt_catch_q <= 1'b0;
         timer_q     <= 32'd0;
         grip_cnt_q  <= 32'd0;
         catch_q     <= 1'b0;
         grip_chg_q  <= 1'b0;
         grip_load_q <= 1'b0;
         ready_q     <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         xita1_q     <= xita1_d;
         xita2_q     <= xita2_d;
         tgt1_q      <= tgt1_d;
         tgt2_q      <= tgt2_d;
         tgt_catch_q <= tgt_catch_d;
         timer_q     <= timer_d;
         grip_cnt_q  <= grip_cnt_d;
         catch_q     <= catch_d;
         grip_chg_q  <= grip_chg_d;
         grip_load_q <= grip_load_d;
         ready_q     <= ready_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign cmd_ready = ready_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign xita1     = xita1_q;
   assign xita2     = xita2_q;
   assign catch     = catch_q;

endmodule

// File: tb/tb_arm_motion_seq.sv
// Directed bench for arm_motion_seq with STEP_DIV=4, GRIP_WAIT=8, home 90/90.
module tb_arm_motion_seq;

   logic        clk;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [31:0] cmd_xita1;
   logic [31:0] cmd_xita2;
   logic        cmd_catch;
   logic [31:0] xita1;
   logic [31:0] xita2;
   logic        catch;
   logic        busy;
   logic        done;

   int n_tests;
   int n_fail;

   arm_motion_seq #(
      .STEP_DIV (4),
      .GRIP_WAIT(8),
      .ANGLE_MAX(180),
      .HOME1    (90),
      .HOME2    (90)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_xita1(cmd_xita1),
      .cmd_xita2(cmd_xita2),
      .cmd_catch(cmd_catch),
      .xita1    (xita1),
      .xita2    (xita2),
      .catch    (catch),
      .busy     (busy),
      .done     (done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      int          cyc;
      logic [31:0] x1;
      logic [31:0] x2;
      logic        c;
      logic        r;
      logic        b;
      logic        d;
   } vec_t;

   vec_t tbl[$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic chk_all(input string nm, input logic [31:0] x1, input logic [31:0] x2,
                          input logic c, input logic r, input logic b, input logic d);
      chk({nm, ".xita1"}, xita1, x1);
      chk({nm, ".xita2"}, xita2, x2);
      chk({nm, ".catch"}, 32'(catch), 32'(c));
      chk({nm, ".cmd_ready"}, 32'(cmd_ready), 32'(r));
      chk({nm, ".busy"}, 32'(busy), 32'(b));
      chk({nm, ".done"}, 32'(done), 32'(d));
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      cmd_valid = 1'b0;
      for (int i = 0; i < n; i++) tick();
      rst = 1'b0;
   endtask

   task automatic set_cmd(input logic v, input logic [31:0] a1, input logic [31:0] a2, input logic c);
      cmd_valid = v;
      cmd_xita1 = a1;
      cmd_xita2 = a2;
      cmd_catch = c;
   endtask

   initial begin
      int idx;
      int done_cnt;
      int overlap_cnt;
      int overshoot_cnt;
      n_tests = 0;
      n_fail  = 0;
      rst = 1'b1;
      set_cmd(1'b0, 32'd0, 32'd0, 1'b0);

      // Scenario 1: reset
      do_reset(3);
      chk_all("reset", 32'd90, 32'd90, 1'b0, 1'b1, 1'b0, 1'b0);

      // Scenario 3: null move straight after reset
      set_cmd(1'b1, 32'd90, 32'd90, 1'b0);
      tick();
      set_cmd(1'b0, 32'd0, 32'd0, 1'b0);
      chk_all("null_c1", 32'd90, 32'd90, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      chk_all("null_c2", 32'd90, 32'd90, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      chk_all("null_c3", 32'd90, 32'd90, 1'b0, 1'b0, 1'b1, 1'b1);
      tick();
      chk_all("null_c4", 32'd90, 32'd90, 1'b0, 1'b1, 1'b0, 1'b0);

      // Scenarios 2 and 5: move with grip change, cmd_valid held with changing data;
      // the second command (93,88,0) is presented on the cycle after done.
      tbl.push_back('{1,  90, 90, 1'b0, 1'b0, 1'b1, 1'b0});
      tbl.push_back('{3,  90, 90, 1'b0, 1'b0, 1'b1, 1'b0});
      tbl.push_back('{4,  91, 89, 1'b0, 1'b0, 1'b1, 1'b0});
      tbl.push_back('{7,  91, 89, 1'b0, 1'b0, 1'b1, 1'b0});
      tbl.push_back('{8,  92, 88, 1'b0, 1'b0, 1'b1, 1'b0});
      tbl.push_back('{11, 92, 88, 1'b0, 1'b0, 1'b1, 1'b0});
      tbl.push_back('{12, 93, 88, 1'b0, 1'b0, 1'b1, 1'b0});
      tbl.push_back('{13, 93, 88, 1'b1, 1'b0, 1'b1, 1'b0});
      tbl.push_back('{21, 93, 88, 1'b1, 1'b0, 1'b1, 1'b0});
      tbl.push_back('{22, 93, 88, 1'b1, 1'b0, 1'b1, 1'b1});
      tbl.push_back('{23, 93, 88, 1'b1, 1'b1, 1'b0, 1'b0});
      tbl.push_back('{24, 93, 88, 1'b1, 1'b0, 1'b1, 1'b0});
      tbl.push_back('{25, 93, 88, 1'b0, 1'b0, 1'b1, 1'b0});
      tbl.push_back('{33, 93, 88, 1'b0, 1'b0, 1'b1, 1'b0});
      tbl.push_back('{34, 93, 88, 1'b0, 1'b0, 1'b1, 1'b1});
      tbl.push_back('{35, 93, 88, 1'b0, 1'b1, 1'b0, 1'b0});
      idx = 0;
      done_cnt = 0;
      overlap_cnt = 0;
      overshoot_cnt = 0;
      for (int k = 0; k <= 35; k++) begin
         if (idx < tbl.size() && tbl[idx].cyc == k) begin
            chk_all($sformatf("move_c%0d", k), tbl[idx].x1, tbl[idx].x2,
                    tbl[idx].c, tbl[idx].r, tbl[idx].b, tbl[idx].d);
            idx++;
         end
         if (done) done_cnt++;
         if (done && cmd_ready) overlap_cnt++;
         if (k <= 22 && (xita1 > 32'd93 || xita1 < 32'd90 || xita2 < 32'd88 || xita2 > 32'd90))
            overshoot_cnt++;
         if (k == 0) set_cmd(1'b1, 32'd93, 32'd88, 1'b1);
         else if (k == 23) set_cmd(1'b1, 32'd93, 32'd88, 1'b0);
         else if (k >= 34) set_cmd(1'b0, 32'd0, 32'd0, 1'b0);
         else set_cmd(1'b1, $urandom_range(0, 255), $urandom_range(0, 255), 1'($urandom_range(0, 1)));
         tick();
      end
      chk("move_tbl_consumed", 32'(idx), 32'(tbl.size()));
      chk("move_done_pulses", 32'(done_cnt), 32'd2);
      chk("move_done_and_ready", 32'(overlap_cnt), 32'd0);
      chk("move_overshoot", 32'(overshoot_cnt), 32'd0);

      // Scenario 4: clamp, from home
      do_reset(1);
      done_cnt = 0;
      overshoot_cnt = 0;
      for (int k = 0; k <= 364; k++) begin
         if (k == 4)   chk_all("clamp_c4", 32'd91, 32'd89, 1'b0, 1'b0, 1'b1, 1'b0);
         if (k == 359) chk_all("clamp_c359", 32'd179, 32'd1, 1'b0, 1'b0, 1'b1, 1'b0);
         if (k == 360) chk_all("clamp_c360", 32'd180, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
         if (k == 361) chk_all("clamp_c361", 32'd180, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
         if (k == 362) chk_all("clamp_c362", 32'd180, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1);
         if (k == 363) chk_all("clamp_c363", 32'd180, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
         if (done) done_cnt++;
         if (xita1 > 32'd180 || xita2 > 32'd90) overshoot_cnt++;
         if (k == 0) set_cmd(1'b1, 32'd200, 32'd0, 1'b0);
         else set_cmd(1'b0, 32'd0, 32'd0, 1'b0);
         tick();
      end
      chk("clamp_done_pulses", 32'(done_cnt), 32'd1);
      chk("clamp_range", 32'(overshoot_cnt), 32'd0);

      // Scenario 6: reset mid-move, then the same command from scratch
      do_reset(1);
      for (int k = 0; k <= 6; k++) begin
         if (k == 4) chk_all("abort_c4", 32'd91, 32'd89, 1'b0, 1'b0, 1'b1, 1'b0);
         if (k == 0) set_cmd(1'b1, 32'd93, 32'd88, 1'b1);
         else set_cmd(1'b0, 32'd0, 32'd0, 1'b0);
         if (k == 6) rst = 1'b1;
         tick();
      end
      rst = 1'b0;
      chk_all("abort_c7", 32'd90, 32'd90, 1'b0, 1'b1, 1'b0, 1'b0);
      done_cnt = 0;
      for (int k = 0; k < 20; k++) begin
         if (done) done_cnt++;
         tick();
      end
      chk("abort_no_done", 32'(done_cnt), 32'd0);
      chk_all("abort_idle", 32'd90, 32'd90, 1'b0, 1'b1, 1'b0, 1'b0);
      done_cnt = 0;
      for (int k = 0; k <= 23; k++) begin
         if (k == 4)  chk_all("rerun_c4", 32'd91, 32'd89, 1'b0, 1'b0, 1'b1, 1'b0);
         if (k == 12) chk_all("rerun_c12", 32'd93, 32'd88, 1'b0, 1'b0, 1'b1, 1'b0);
         if (k == 13) chk_all("rerun_c13", 32'd93, 32'd88, 1'b1, 1'b0, 1'b1, 1'b0);
         if (k == 21) chk_all("rerun_c21", 32'd93, 32'd88, 1'b1, 1'b0, 1'b1, 1'b0);
         if (k == 22) chk_all("rerun_c22", 32'd93, 32'd88, 1'b1, 1'b0, 1'b1, 1'b1);
         if (k == 23) chk_all("rerun_c23", 32'd93, 32'd88, 1'b1, 1'b1, 1'b0, 1'b0);
         if (done) done_cnt++;
         if (k == 0) set_cmd(1'b1, 32'd93, 32'd88, 1'b1);
         else set_cmd(1'b0, 32'd0, 32'd0, 1'b0);
         tick();
      end
      chk("rerun_done_pulses", 32'(done_cnt), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/arm_motion_seq.md
# arm_motion_seq

Command sequencer that sits directly upstream of the arm angle/PWM stage. It accepts one move command at a time, naming two target joint angles and a gripper state, over a valid/ready handshake. It ramps the two joint-angle outputs toward the targets at a fixed rate of one degree per step, then applies the gripper change and holds for a settle time. Its outputs xita1, xita2 and catch drive the arm angle stage unchanged.

## Interface
- STEP_DIV, 500_000: clock cycles per 1-degree step (10 ms at 50 MHz); legal range ≥ 1.
- GRIP_WAIT, 25_000_000: cycles held after a gripper change (0.5 s); legal range ≥ 1.
- ANGLE_MAX, 180: largest legal angle in degrees; larger targets are clamped to it.
- HOME1, 90: reset value of xita1 in degrees.
- HOME2, 90: reset value of xita2 in degrees.

Reset: one clock; reset is synchronous and active-high.

- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_xita1  in  32  target angle for joint 1, unsigned degrees.
- cmd_xita2  in  32  target angle for joint 2, unsigned degrees.
- cmd_catch  in  1  target gripper state (1 = closed).
- xita1  out  32  current joint-1 angle, unsigned degrees.
- xita2  out  32  current joint-2 angle, unsigned degrees.
- catch  out  1  current gripper command.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a command completes.

## Operation
- States: IDLE, MOVE, GRIP, DONE.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid & cmd_ready, latch tgt1 = min(cmd_xita1, ANGLE_MAX), tgt2 = min(cmd_xita2, ANGLE_MAX) and tgt_catch.
  - Clear the step timer and go to MOVE.
- MOVE:
  - The step timer counts 0 … STEP_DIV−1.
  - On the cycle the timer equals STEP_DIV−1:
    - each axis whose angle differs from its target moves 1 toward it (+1 or −1);
    - axes move independently, and an axis that has reached its target stays there;
    - the timer wraps to 0.
  - When xita1 == tgt1 and xita2 == tgt2, go to GRIP on the next edge. This check uses registered values.
  - A command whose targets equal the current angles spends exactly 1 cycle in MOVE.
- GRIP:
  - If tgt_catch != catch: on entry, update catch and load the wait counter with GRIP_WAIT−1. Remain in GRIP until the counter reaches 0, then go to DONE.
  - If tgt_catch == catch: go to DONE after 1 cycle, with no wait.
- DONE: done = 1 for exactly 1 cycle, then IDLE.
- Angles never leave 0 … ANGLE_MAX. No underflow is possible, because targets are clamped and steps stop at the target.
- cmd_valid is ignored while busy. The latched command does not change mid-operation.
- Counter widths must hold STEP_DIV−1 and GRIP_WAIT−1. Use 32 bits.

## Timing
- Reset values:
  - xita1 = HOME1, xita2 = HOME2, catch = 0;
  - state IDLE, cmd_ready = 1, busy = 0, done = 0;
  - timers = 0.
- Reset takes effect at the next clk edge while rst = 1. This includes reset mid-MOVE or mid-GRIP, which aborts the command, returns the angles to HOME1/HOME2 and drops done.
- Accept edge is T0. From T0+1: busy = 1, cmd_ready = 0.
- With D = max(|tgt1−xita1|, |tgt2−xita2|) at T0 and D > 0:
  - the first step appears at T0+STEP_DIV;
  - the last step appears at T0+D·STEP_DIV;
  - GRIP is entered at T0+D·STEP_DIV+1.
- With D = 0, GRIP is entered at T0+2.
- The catch output changes on the first GRIP cycle, i.e. at the same edge that enters GRIP.
- done:
  - high for 1 cycle, GRIP_WAIT+1 cycles after GRIP entry when catch changes;
  - high for 1 cycle, 1 cycle after GRIP entry otherwise.
- The cycle after done: cmd_ready = 1, busy = 0. A new command can be accepted on that cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
Parameters for all scenarios: STEP_DIV = 4, GRIP_WAIT = 8, HOME1 = HOME2 = 90.

1. Reset.
   - Stimulus: hold rst for 3 cycles, then release.
   - Required: xita1 = xita2 = 90, catch = 0, cmd_ready = 1, busy = 0, done = 0.
2. Move with grip change.
   - Stimulus: command (93, 88, catch = 1).
   - Required:
     - xita1 = 91, 92, 93 at T0+4, +8, +12;
     - xita2 = 89, 88 at T0+4, +8;
     - catch = 1 at T0+13;
     - done pulses exactly once, 9 cycles later;
     - xita1 and xita2 never overshoot their targets.
3. Null move.
   - Stimulus: command (90, 90, catch = 0) directly after reset.
   - Required: no angle change; no catch change; done pulses at T0+3.
4. Clamp.
   - Stimulus: command (200, 0, catch = 0).
   - Required: xita1 stops at 180; xita2 reaches 0; done follows D = 90 steps.
5. Busy and backpressure.
   - Stimulus: hold cmd_valid high with changing data throughout scenario 2.
   - Required:
     - only the first command is applied;
     - a second command is accepted on the cycle after done;
     - done is never high while cmd_ready = 1 in the same cycle.
6. Reset mid-operation.
   - Stimulus: assert rst at T0+6 during a move.
   - Required: the next cycle shows the reset values; no done pulse; the next command behaves as in scenario 2.
